lpif_rx_packer: RTL and testbench
=================================

Name: lpif_rx_packer

Overview:
- Parametrised successor to the LPIF RX control/data-flow stage; sits between the RX framing/deskew logic and the LPIF link-layer RX interface.
- Each cycle it compacts the valid bytes of an NBYTES-wide beat, removing holes left by stripped framing and SKP symbols.
- Compacted bytes are accumulated across cycles in a 2*NBYTES byte buffer. The block emits dense full beats, or a partial beat on packet end or idle timeout.
- Supports link-layer backpressure and registers the LPIF sideband: speed mode, state status and force-detect.

Parameters:
- NBYTES, 64, byte lanes per beat; power of 2, 1..64.
- FLUSH_TIMEOUT, 8, idle cycles before a partial beat is flushed; 0 disables timeout flush.
- CW, $clog2(2*NBYTES+1), derived width of the fill counter; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- packetValid  in  NBYTES  per-byte valid.
- packetData  in  8*NBYTES  byte k on bits [8k+7:8k].
- tlpstart, tlpend, edb, dllpstart, dllpend  in  NBYTES each  per-byte markers; only meaningful where packetValid=1.
- rx_ready  out  1  upstream may present a beat; combinational, equals (cnt <= NBYTES).
- lp_rx_ready  in  1  link layer accepts the current output beat.
- pl_valid  out  NBYTES  output byte valid; always contiguous from lane 0.
- pl_data  out  8*NBYTES  output bytes.
- pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dllpstart, pl_dllpend  out  NBYTES each  markers, byte-aligned with pl_data (no shift).
- lp_force_detect  in  1  force-detect request.
- GEN  in  3  current generation.
- state  in  4  LTSSM state.
- pl_speedmode  out  3  encoded speed.
- pl_state_sts  out  4  registered state.
- ltssmForceDetect  out  1  registered lp_force_detect.

Behaviour:
- Reset, asynchronous while reset=1: all outputs 0, cnt=0, idle counter 0, buffer contents discarded. rx_ready therefore reads 1 once reset is applied.
- Input fire: (|packetValid) & rx_ready. Beats with packetValid=0 are ignored entirely. Upstream must hold its beat while rx_ready=0.
- Compaction:
  - The k-th set bit of packetValid, counted in ascending lane order, maps to compacted byte k.
  - The data byte and all five markers travel with it.
  - n = popcount(packetValid).
- Buffer: byte array of 2*NBYTES entries, each 8 data bits plus 5 marker bits, with fill count cnt.
  - Append writes at positions cnt..cnt+n-1.
  - The emission decision uses the pre-append buffer contents.
- Output register load:
  - Loads when pl_valid==0 or lp_rx_ready=1.
  - If cnt >= NBYTES: emit bytes 0..NBYTES-1; pl_valid all ones.
  - Else if cnt>0 and (any buffered byte has tlpend|dllpend|edb set, or (FLUSH_TIMEOUT!=0 and idle==FLUSH_TIMEOUT)): emit cnt bytes; pl_valid = low cnt bits set, remaining lanes 0 with data and markers 0.
  - Otherwise: pl_valid=0, and pl_data/markers are 0.
  - Emitted bytes are removed and the remainder shifts to position 0.
- Stall: while pl_valid!=0 and lp_rx_ready=0, all pl_* hold and nothing is emitted.
- Same-edge update: cnt_next = cnt - emitted + (fire ? n : 0). Capacity is never exceeded because rx_ready requires cnt<=NBYTES and n<=NBYTES.
- Latency: minimum 2 clk edges from input fire to pl_valid, because the byte is appended on edge 1 and emitted on edge 2.
- Idle counter:
  - Cleared on fire or when cnt==0.
  - Otherwise increments each cycle and saturates at FLUSH_TIMEOUT.
  - Cleared after a timeout flush.
- Sideband, 1-cycle registered, independent of the data path:
  - pl_state_sts <= state; ltssmForceDetect <= lp_force_detect.
  - pl_speedmode: GEN 1→0, 2→1, 3→2, 4→3, 5→4, other→3'b111.
- Ordering: bytes leave in exactly the order they arrived. Markers are never dropped or merged.

Test Plan:
- Reset: NBYTES=8; assert reset mid-accumulation with cnt=5 → next cycle all outputs 0, rx_ready=1, and the old bytes never appear on pl_data.
- Compaction: NBYTES=8; beat1 valid=8'b1011_0110, data lanes = lane index; beat2 valid=8'hFF with data 0x10..0x17 → first output beat data bytes 1,2,4,5,7,0x10,0x11,0x12 with pl_valid=8'hFF. Remaining 5 bytes are held until end or timeout.
- End flush: 3 valid bytes with tlpend on the 3rd, no further input → pl_valid=8'b0000_0111 two edges later, with pl_tlpend=8'b0000_0100.
- Timeout: FLUSH_TIMEOUT=4; 2 valid bytes, no markers, then idle → partial beat pl_valid=8'h03 appears after 4 idle cycles plus 1 load edge. With FLUSH_TIMEOUT=0 it never appears.
- Backpressure: hold lp_rx_ready=0 while feeding full beats → rx_ready drops once cnt>8, pl_* stay stable, and no bytes are lost or duplicated after lp_rx_ready returns to 1.
- Sideband: GEN=3, state=4'hA, lp_force_detect=1 → next edge pl_speedmode=3'b010, pl_state_sts=4'hA, ltssmForceDetect=1. GEN=6 → pl_speedmode=3'b111.

Source files
------------

// File: rtl/lpif_rx_packer.sv
// LPIF RX packer: compacts sparse valid bytes of each incoming beat, accumulates
// them in a 2*NBYTES byte buffer and emits dense beats toward the link layer.
// A partial beat leaves on a packet/DLLP end marker or after an idle timeout.
// Also registers the LPIF sideband (speed mode, state status, force-detect).
module lpif_rx_packer #(
    parameter int  NBYTES        = 64,
    parameter int  FLUSH_TIMEOUT = 8,
    localparam int CW            = $clog2(2*NBYTES+1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBYTES-1:0]   packetValid,
    input  logic [8*NBYTES-1:0] packetData,
    input  logic [NBYTES-1:0]   tlpstart,
    input  logic [NBYTES-1:0]   tlpend,
    input  logic [NBYTES-1:0]   edb,
    input  logic [NBYTES-1:0]   dllpstart,
    input  logic [NBYTES-1:0]   dllpend,
    output logic                rx_ready,
    input  logic                lp_rx_ready,
    output logic [NBYTES-1:0]   pl_valid,
    output logic [8*NBYTES-1:0] pl_data,
    output logic [NBYTES-1:0]   pl_tlpstart,
    output logic [NBYTES-1:0]   pl_tlpend,
    output logic [NBYTES-1:0]   pl_tlpedb,
    output logic [NBYTES-1:0]   pl_dllpstart,
    output logic [NBYTES-1:0]   pl_dllpend,
    input  logic                lp_force_detect,
    input  logic [2:0]          GEN,
    input  logic [3:0]          state,
    output logic [2:0]          pl_speedmode,
    output logic [3:0]          pl_state_sts,
    output logic                ltssmForceDetect
);
    localparam int DEPTH = 2*NBYTES;
    localparam int IW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT+1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);

    // One buffered byte with the markers that travel with it
    typedef struct packed {
        logic       de;
        logic       ds;
        logic       eb;
        logic       te;
        logic       ts;
        logic [7:0] data;
    } ent_t;

    ent_t          bq   [DEPTH];
    ent_t          bd   [DEPTH];
    ent_t          comp [NBYTES];
    logic [CW-1:0] pos  [NBYTES];
    logic [CW-1:0] cnt, n_in, em, base;
    logic [IW-1:0] idle;
    logic          fire, load, has_end, timeout, flush_part;

    assign rx_ready = (cnt <= CW'(NBYTES));
    assign fire     = (|packetValid) && rx_ready;
    assign load     = (pl_valid == '0) || lp_rx_ready;
    assign timeout  = (FLUSH_TIMEOUT != 0) && (idle == IDLE_MAX);
    assign base     = cnt - em;

    // Prefix count of valid lanes: lane k lands in compacted slot pos[k]
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NBYTES; k++) begin
            pos[k] = acc;
            acc    = acc + CW'(packetValid[k]);
        end
        n_in = acc;
    end

    // Gather: slot j can only be fed from lanes j and above
    always_comb begin
        for (int j = 0; j < NBYTES; j++) begin
            comp[j] = '0;
            for (int k = j; k < NBYTES; k++)
                if (packetValid[k] && pos[k] == CW'(j))
                    comp[j] = {dllpend[k], dllpstart[k], edb[k], tlpend[k], tlpstart[k],
                               packetData[8*k +: 8]};
        end
    end

    // Any end-of-packet style marker currently sitting in the buffer
    always_comb begin
        has_end = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < cnt && (bq[i].te || bq[i].eb || bq[i].de)) has_end = 1'b1;
    end

    // Emission decision, taken on the pre-append contents
    always_comb begin
        em         = '0;
        flush_part = 1'b0;
        if (load) begin
            if (cnt >= CW'(NBYTES)) begin
                em = CW'(NBYTES);
            end else if (cnt != '0 && (has_end || timeout)) begin
                em         = cnt;
                flush_part = 1'b1;
            end
        end
    end

    // Next buffer: drop emitted head, shift remainder down, append new bytes behind it
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bd[i] = '0;
            for (int s = 0; s <= NBYTES && i + s < DEPTH; s++)
                if (em == CW'(s) && CW'(i + s) < cnt) bd[i] = bq[i + s];
            for (int j = 0; j < NBYTES; j++)
                if (fire && CW'(j) < n_in && base + CW'(j) == CW'(i)) bd[i] = comp[j];
        end
    end

    // Buffer contents, fill count and idle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            idle <= '0;
            for (int i = 0; i < DEPTH; i++) bq[i] <= '0;
        end else begin
            cnt <= base + (fire ? n_in : '0);
            for (int i = 0; i < DEPTH; i++) bq[i] <= bd[i];
            if (fire || cnt == '0 || flush_part) idle <= '0;
            else if (idle != IDLE_MAX)           idle <= idle + 1'b1;
        end
    end

    // Output beat register: reloads (possibly with an empty beat) whenever not stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pl_valid     <= '0;
            pl_data      <= '0;
            pl_tlpstart  <= '0;
            pl_tlpend    <= '0;
            pl_tlpedb    <= '0;
            pl_dllpstart <= '0;
            pl_dllpend   <= '0;
        end else if (load) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (CW'(i) < em) begin
                    pl_valid[i]       <= 1'b1;
                    pl_data[8*i +: 8] <= bq[i].data;
                    pl_tlpstart[i]    <= bq[i].ts;
                    pl_tlpend[i]      <= bq[i].te;
                    pl_tlpedb[i]      <= bq[i].eb;
                    pl_dllpstart[i]   <= bq[i].ds;
                    pl_dllpend[i]     <= bq[i].de;
                end else begin
                    pl_valid[i]       <= 1'b0;
                    pl_data[8*i +: 8] <= 8'h00;
                    pl_tlpstart[i]    <= 1'b0;
                    pl_tlpend[i]      <= 1'b0;
                    pl_tlpedb[i]      <= 1'b0;
                    pl_dllpstart[i]   <= 1'b0;
                    pl_dllpend[i]     <= 1'b0;
                end
            end
        end
    end

    // Sideband: one-cycle registered, independent of the byte path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pl_speedmode     <= '0;
            pl_state_sts     <= '0;
            ltssmForceDetect <= 1'b0;
        end else begin
            pl_state_sts     <= state;
            ltssmForceDetect <= lp_force_detect;
            case (GEN)
                3'd1:    pl_speedmode <= 3'd0;
                3'd2:    pl_speedmode <= 3'd1;
                3'd3:    pl_speedmode <= 3'd2;
                3'd4:    pl_speedmode <= 3'd3;
                3'd5:    pl_speedmode <= 3'd4;
                default: pl_speedmode <= 3'b111;
            endcase
        end
    end

endmodule

// File: tb/tb_lpif_rx_packer.sv
// Bench for lpif_rx_packer (NBYTES=8). A byte-queue reference model advances on
// every rising edge; tasks compare DUT outputs against it on falling edges plus
// targeted constant checks. A second DUT with timeout disabled checks the no-flush case.
module tb_lpif_rx_packer;
    localparam int N  = 8;
    localparam int FT = 4;
    localparam int OW = 1 + 14*N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   packetValid = '0, tlpstart = '0, tlpend = '0, edb = '0, dllpstart = '0, dllpend = '0;
    logic [8*N-1:0] packetData = '0;
    logic           lp_rx_ready = 1'b1, lp_force_detect = 1'b0;
    logic [2:0]     GEN = 3'd0;
    logic [3:0]     state = 4'd0;

    logic           rx_ready, ltssmForceDetect;
    logic [N-1:0]   pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dllpstart, pl_dllpend;
    logic [8*N-1:0] pl_data;
    logic [2:0]     pl_speedmode;
    logic [3:0]     pl_state_sts;

    logic           z_rx_ready, z_fd;
    logic [N-1:0]   z_valid, z_ts, z_te, z_eb, z_ds, z_de;
    logic [8*N-1:0] z_data;
    logic [2:0]     z_spd;
    logic [3:0]     z_sts;

    lpif_rx_packer #(.NBYTES(N), .FLUSH_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset), .packetValid(packetValid), .packetData(packetData),
        .tlpstart(tlpstart), .tlpend(tlpend), .edb(edb), .dllpstart(dllpstart), .dllpend(dllpend),
        .rx_ready(rx_ready), .lp_rx_ready(lp_rx_ready), .pl_valid(pl_valid), .pl_data(pl_data),
        .pl_tlpstart(pl_tlpstart), .pl_tlpend(pl_tlpend), .pl_tlpedb(pl_tlpedb),
        .pl_dllpstart(pl_dllpstart), .pl_dllpend(pl_dllpend), .lp_force_detect(lp_force_detect),
        .GEN(GEN), .state(state), .pl_speedmode(pl_speedmode), .pl_state_sts(pl_state_sts),
        .ltssmForceDetect(ltssmForceDetect));

    lpif_rx_packer #(.NBYTES(N), .FLUSH_TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .packetValid(packetValid), .packetData(packetData),
        .tlpstart(tlpstart), .tlpend(tlpend), .edb(edb), .dllpstart(dllpstart), .dllpend(dllpend),
        .rx_ready(z_rx_ready), .lp_rx_ready(lp_rx_ready), .pl_valid(z_valid), .pl_data(z_data),
        .pl_tlpstart(z_ts), .pl_tlpend(z_te), .pl_tlpedb(z_eb),
        .pl_dllpstart(z_ds), .pl_dllpend(z_de), .lp_force_detect(lp_force_detect),
        .GEN(GEN), .state(state), .pl_speedmode(z_spd), .pl_state_sts(z_sts),
        .ltssmForceDetect(z_fd));

    int total = 0;
    int bad   = 0;

    // ---------------- reference model: ordered byte queue ----------------
    logic [12:0]    mq[$];               // {dllpend,dllpstart,edb,tlpend,tlpstart,data}
    logic [12:0]    m_e;
    int             m_cnt = 0, m_idle = 0, m_sz, m_take;
    bit             m_fire, m_end, m_part;
    logic [N-1:0]   m_valid = '0, m_ts = '0, m_te = '0, m_eb = '0, m_ds = '0, m_de = '0;
    logic [8*N-1:0] m_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_idle = 0;
            m_valid = '0; m_data = '0; m_ts = '0; m_te = '0; m_eb = '0; m_ds = '0; m_de = '0;
        end else begin
            m_sz   = mq.size();
            m_fire = (packetValid != '0) && (m_sz <= N);
            m_end  = 1'b0;
            foreach (mq[i]) if (mq[i][9] | mq[i][10] | mq[i][12]) m_end = 1'b1;
            m_take = 0;
            m_part = 1'b0;
            if (m_valid == '0 || lp_rx_ready) begin
                if (m_sz >= N) m_take = N;
                else if (m_sz > 0 && (m_end || (FT != 0 && m_idle == FT))) begin
                    m_take = m_sz;
                    m_part = 1'b1;
                end
                m_valid = '0; m_data = '0; m_ts = '0; m_te = '0; m_eb = '0; m_ds = '0; m_de = '0;
                for (int i = 0; i < m_take; i++) begin
                    m_e = mq.pop_front();
                    m_valid[i] = 1'b1;
                    m_data[8*i +: 8] = m_e[7:0];
                    m_ts[i] = m_e[8];  m_te[i] = m_e[9];  m_eb[i] = m_e[10];
                    m_ds[i] = m_e[11]; m_de[i] = m_e[12];
                end
            end
            if (m_fire || m_sz == 0 || m_part) m_idle = 0;
            else if (m_idle < FT)              m_idle = m_idle + 1;
            if (m_fire)
                for (int k = 0; k < N; k++)
                    if (packetValid[k])
                        mq.push_back({dllpend[k], dllpstart[k], edb[k], tlpend[k], tlpstart[k],
                                      packetData[8*k +: 8]});
        end
        m_cnt = mq.size();
    end

    wire [OW-1:0] obs   = {rx_ready, pl_valid, pl_data, pl_tlpstart, pl_tlpend, pl_tlpedb,
                           pl_dllpstart, pl_dllpend};
    wire [OW-1:0] m_vec = {(m_cnt <= N) ? 1'b1 : 1'b0, m_valid, m_data, m_ts, m_te, m_eb, m_ds, m_de};
    wire [OW-1:0] RST_VEC = {1'b1, {(OW-1){1'b0}}};

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic set_beat(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic [N-1:0] te);
        packetValid = v; packetData = d; tlpend = te;
        tlpstart = '0; edb = '0; dllpstart = '0; dllpend = '0;
    endtask

    task automatic idle_in;
        set_beat('0, '0, '0);
    endtask

    task automatic rand_beat;
        packetValid = ($urandom_range(3) == 0) ? '0 : N'($urandom);
        for (int k = 0; k < N; k++) packetData[8*k +: 8] = 8'($urandom);
        tlpstart  = N'($urandom & $urandom);
        tlpend    = N'($urandom & $urandom & $urandom);
        edb       = N'($urandom & $urandom & $urandom & $urandom);
        dllpstart = N'($urandom & $urandom);
        dllpend   = N'($urandom & $urandom & $urandom);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; idle_in(); lp_rx_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_init got=%h want=%h", obs, RST_VEC); end
        total++; if ({pl_speedmode, pl_state_sts, ltssmForceDetect} !== 8'h00) begin
            bad++; $display("FAIL reset_init_sb got=%h want=00", {pl_speedmode, pl_state_sts, ltssmForceDetect}); end
        reset = 1'b0;
        GEN = 3'd3; state = 4'h5; lp_force_detect = 1'b1;
        set_beat(8'h1F, 64'h000000A4A3A2A1A0, '0);
        @(negedge clk);
        total++; if (obs !== m_vec) begin bad++; $display("FAIL reset_fill got=%h want=%h", obs, m_vec); end
        idle_in();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, RST_VEC); end
        total++; if ({pl_speedmode, pl_state_sts, ltssmForceDetect} !== 8'h00) begin
            bad++; $display("FAIL reset_async_sb got=%h want=00", {pl_speedmode, pl_state_sts, ltssmForceDetect}); end
        GEN = 3'd0; state = 4'h0; lp_force_detect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        set_beat(8'h07, 64'h0000000000C2C1C0, 8'h04);
        @(negedge clk);
        total++; if (obs !== m_vec) begin bad++; $display("FAIL reset_new1 got=%h want=%h", obs, m_vec); end
        idle_in();
        @(negedge clk);
        total++; if (pl_valid !== 8'h07 || pl_data !== 64'h0000000000C2C1C0) begin
            bad++; $display("FAIL reset_no_old got=%h/%h want=07/0000000000c2c1c0", pl_valid, pl_data); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL reset_tail c%0d got=%h want=%h", c, obs, m_vec); end
        end
    endtask

    task automatic test_compaction;
        do_reset();
        set_beat(8'b1011_0110, 64'h0706050403020100, '0);
        @(negedge clk);
        total++; if (obs !== m_vec) begin bad++; $display("FAIL comp_b1 got=%h want=%h", obs, m_vec); end
        set_beat(8'hFF, 64'h1716151413121110, '0);
        @(negedge clk);
        total++; if (obs !== m_vec) begin bad++; $display("FAIL comp_b2 got=%h want=%h", obs, m_vec); end
        idle_in();
        @(negedge clk);
        total++; if (pl_valid !== 8'hFF || pl_data !== 64'h1211100705040201) begin
            bad++; $display("FAIL comp_beat got=%h/%h want=ff/1211100705040201", pl_valid, pl_data); end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL comp_tail c%0d got=%h want=%h", c, obs, m_vec); end
        end
    endtask

    task automatic test_end_flush;
        logic [8*N-1:0] d;
        do_reset();
        for (int k = 0; k < N; k++) d[8*k +: 8] = 8'($urandom);
        set_beat(8'h07, d, 8'h04);
        @(negedge clk);
        total++; if (pl_valid !== 8'h00) begin bad++; $display("FAIL end_early got=%h want=00", pl_valid); end
        idle_in();
        @(negedge clk);
        total++; if (pl_valid !== 8'h07 || pl_tlpend !== 8'h04) begin
            bad++; $display("FAIL end_flush got=%h/%h want=07/04", pl_valid, pl_tlpend); end
        total++; if (pl_data !== {40'h0, d[23:0]}) begin
            bad++; $display("FAIL end_data got=%h want=%h", pl_data, {40'h0, d[23:0]}); end
        @(negedge clk);
        total++; if (obs !== m_vec) begin bad++; $display("FAIL end_after got=%h want=%h", obs, m_vec); end
    endtask

    task automatic test_timeout;
        logic [N-1:0] want;
        do_reset();
        set_beat(8'h03, 64'h000000000000BEEF, '0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) idle_in();
            want = (k == 6) ? 8'h03 : 8'h00;
            total++; if (pl_valid !== want) begin bad++; $display("FAIL timeout k%0d got=%h want=%h", k, pl_valid, want); end
            total++; if (obs !== m_vec) begin bad++; $display("FAIL timeout_model k%0d got=%h want=%h", k, obs, m_vec); end
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++; if (z_valid !== 8'h00) begin bad++; $display("FAIL no_timeout k%0d got=%h want=00", k, z_valid); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]     sent[$];
        logic [7:0]     got[$];
        logic [8*N-1:0] d, first;
        int             nb = 0;
        do_reset();
        lp_rx_ready = 1'b0;
        first = '0;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL bp_fill t%0d got=%h want=%h", t, obs, m_vec); end
            if (t >= 4) begin
                total++; if (pl_valid !== 8'hFF || pl_data !== first) begin
                    bad++; $display("FAIL bp_hold t%0d got=%h/%h want=ff/%h", t, pl_valid, pl_data, first); end
            end
            if (rx_ready) begin
                for (int k = 0; k < N; k++) begin d[8*k +: 8] = 8'($urandom); sent.push_back(d[8*k +: 8]); end
                if (nb == 0) first = d;
                nb++;
                set_beat(8'hFF, d, '0);
            end else idle_in();
        end
        total++; if (rx_ready !== 1'b0 || nb != 3) begin
            bad++; $display("FAIL bp_ready got=%b beats=%0d want=0 beats=3", rx_ready, nb); end
        @(negedge clk);
        idle_in();
        lp_rx_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL bp_drain c%0d got=%h want=%h", c, obs, m_vec); end
            for (int i = 0; i < N; i++) if (pl_valid[i]) got.push_back(pl_data[8*i +: 8]);
        end
        total++; if (got.size() != sent.size() || got != sent) begin
            bad++; $display("FAIL bp_order got=%0d bytes want=%0d bytes (content differs or count)", got.size(), sent.size()); end
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL random c%0d got=%h want=%h", c, obs, m_vec); end
            lp_rx_ready = (c % 64 < 8) ? 1'b0 : ($urandom_range(3) != 0);
            if (rx_ready) rand_beat(); else idle_in();
        end
        idle_in();
        lp_rx_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++; if (obs !== m_vec) begin bad++; $display("FAIL random_drain c%0d got=%h want=%h", c, obs, m_vec); end
        end
    endtask

    task automatic test_sideband;
        logic [2:0] ws;
        logic [3:0] st;
        @(negedge clk);
        GEN = 3'd3; state = 4'hA; lp_force_detect = 1'b1;
        @(negedge clk);
        total++; if ({pl_speedmode, pl_state_sts, ltssmForceDetect} !== {3'b010, 4'hA, 1'b1}) begin
            bad++; $display("FAIL sb_gen3 got=%h want=%h", {pl_speedmode, pl_state_sts, ltssmForceDetect}, {3'b010, 4'hA, 1'b1}); end
        GEN = 3'd6;
        @(negedge clk);
        total++; if (pl_speedmode !== 3'b111) begin bad++; $display("FAIL sb_gen6 got=%b want=111", pl_speedmode); end
        for (int g = 0; g < 8; g++) begin
            st = 4'($urandom);
            GEN = 3'(g); state = st; lp_force_detect = g[0];
            @(negedge clk);
            ws = (g >= 1 && g <= 5) ? 3'(g - 1) : 3'b111;
            total++; if ({pl_speedmode, pl_state_sts, ltssmForceDetect} !== {ws, st, g[0]}) begin
                bad++; $display("FAIL sb_gen%0d got=%h want=%h", g, {pl_speedmode, pl_state_sts, ltssmForceDetect}, {ws, st, g[0]}); end
        end
    endtask

    initial begin
        test_reset();
        test_compaction();
        test_end_flush();
        test_timeout();
        test_backpressure();
        test_random();
        test_sideband();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
